// File: rtl/lfsr_mem_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_mem_pkg
//
// Shared definitions for the LFSR-addressed associative memory. The write side
// (lfsr_mem_writer) and the search side both import this package, so the
// address sequence, seed and capacity are defined in exactly one place.
//
// Contents:
//   wr_state_e           - writer FSM state encoding (IDLE / WRITE / FULL)
//   LFSR16_TAPS          - feedback taps of x^16 + x^14 + x^13 + x^11 + 1
//   LFSR16_SEED_DEFAULT  - power-on / restart address, also the substitute
//                          used whenever a zero seed is configured
//   MAX_WRITES_16        - number of distinct nonzero states of the LFSR
//   lfsr16_next()        - one Fibonacci step of the 16-bit LFSR
// -----------------------------------------------------------------------------
package lfsr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } wr_state_e;

  // Bits 15, 13, 12 and 10 feed the XOR that becomes the new LSB.
  localparam logic [15:0] LFSR16_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR16_SEED_DEFAULT = 16'h0001;
  localparam logic [15:0] MAX_WRITES_16       = 16'hFFFF;

  // Fibonacci form: shift left, the parity of the tapped bits enters at bit 0.
  // From any nonzero state the sequence visits all 65535 nonzero values.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR16_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_mem_writer_lfsr16_step.sv
// -----------------------------------------------------------------------------
// lfsr16_step
//
// Purely combinational next-state of the 16-bit maximal-length LFSR. Kept as a
// separate module so the search-side address generator instantiates the very
// same logic and both sides walk an identical address sequence.
//
// Ports:
//   state_i  in  16  current LFSR state
//   next_o   out 16  LFSR state after one step
// -----------------------------------------------------------------------------
module lfsr16_step
  import lfsr_mem_pkg::*;
(
  input  logic [15:0] state_i,
  output logic [15:0] next_o
);

  assign next_o = lfsr16_next(state_i);

endmodule

// File: rtl/lfsr_mem_writer.sv
// -----------------------------------------------------------------------------
// lfsr_mem_writer
//
// Write-side sequencer of the LFSR-addressed associative memory. Each byte
// accepted on the Data_in / Data_valid / Data_ready handshake is written to the
// memory at the current LFSR address, after which the LFSR advances and the
// write count increments. Once MAX_WRITES bytes have been stored the writer
// parks in FULL and refuses further data until Clear or Reset.
//
// Timing: a handshake at edge N raises Mem_WR for the cycle after N; at the
// following edge the LFSR steps and WR_Count increments. One byte is taken
// every two cycles at most.
//
// Parameters:
//   ADDR_W      address / LFSR width (16 only)
//   DATA_W      data byte width
//   SEED        first address after Reset/Clear; zero is replaced by 16'h0001
//   MAX_WRITES  writes accepted before Full
//
// Ports:
//   Clock        in   1       system clock, rising edge
//   Reset        in   1       synchronous reset, active low
//   Clear        in   1       synchronous restart, active high
//   Data_in      in   DATA_W  byte to store
//   Data_valid   in   1       Data_in valid
//   Data_ready   out  1       writer accepts Data_in this cycle
//   Mem_Address  out  ADDR_W  registered memory write address
//   Mem_Data     out  DATA_W  registered memory write data
//   Mem_WR       out  1       registered one-cycle write strobe
//   WR_Count     out  16      number of completed writes
//   Full         out  1       WR_Count has reached MAX_WRITES
//   Busy         out  1       a write is in flight (state WRITE)
// -----------------------------------------------------------------------------
module lfsr_mem_writer
  import lfsr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter logic [15:0] SEED       = LFSR16_SEED_DEFAULT,
  parameter logic [15:0] MAX_WRITES = MAX_WRITES_16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Data_valid,
  output logic              Data_ready,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_WR,
  output logic [15:0]       WR_Count,
  output logic              Full,
  output logic              Busy
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? LFSR16_SEED_DEFAULT : SEED;

  // Count increment that sticks at MAX_WRITES instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == MAX_WRITES) ? v : v + 16'd1;
  endfunction

  wr_state_e         state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       lfsr_step;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              ready;
  logic              full;
  logic              accept;

  lfsr16_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_step)
  );

  assign cnt_inc = sat_inc(cnt_q);
  assign full    = (cnt_q == MAX_WRITES);

  // Ready is gated by Reset and Clear so that nothing can be accepted in a
  // cycle whose edge is going to restart the writer anyway.
  assign ready  = Reset && !Clear && (state_q == IDLE) && !full;
  assign accept = Data_valid && ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (Clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = WRITE;
        WRITE:   state_d = (cnt_inc == MAX_WRITES) ? FULL : IDLE;
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Data_ready = ready;
    Full       = full;
    Busy       = (state_q == WRITE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state. Address and data only change on a handshake so they
  // hold the last written values between writes. A Clear arriving during
  // WRITE cannot recall the strobe already on the bus, but it does stop the
  // LFSR step and the count increment so the restart is clean.
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = 1'b0;
    if (Clear) begin
      lfsr_d = SEED_EFF;
      cnt_d  = 16'h0000;
    end else if (accept) begin
      addr_d = lfsr_q;
      data_d = Data_in;
      wr_d   = 1'b1;
    end else if (state_q == WRITE) begin
      lfsr_d = lfsr_step;
      cnt_d  = cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lfsr_q <= SEED_EFF;
      cnt_q  <= 16'h0000;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
    end
  end

  assign Mem_Address = addr_q;
  assign Mem_Data    = data_q;
  assign Mem_WR      = wr_q;
  assign WR_Count    = cnt_q;

endmodule

// File: tb/tb_lfsr_mem_writer.sv
module tb_lfsr_mem_writer;

  localparam int          NI    = 2;
  localparam logic [15:0] MAX_S = 16'd4;
  localparam logic [15:0] MAX_M = 16'd1200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic       dv;
  logic [7:0] din;

  logic [NI-1:0]       rdy, wr, full, busy;
  logic [NI-1:0][15:0] addr, cnt;
  logic [NI-1:0][7:0]  mdat;

  // Two writers share the stimulus: a 4-deep one for the Full behaviour and a
  // larger one for sequence, uniqueness and soak checks.
  lfsr_mem_writer #(.MAX_WRITES(MAX_S)) u_small (
    .Clock(clk), .Reset(rst_n), .Clear(clr), .Data_in(din), .Data_valid(dv),
    .Data_ready(rdy[0]), .Mem_Address(addr[0]), .Mem_Data(mdat[0]),
    .Mem_WR(wr[0]), .WR_Count(cnt[0]), .Full(full[0]), .Busy(busy[0])
  );

  lfsr_mem_writer #(.MAX_WRITES(MAX_M)) u_main (
    .Clock(clk), .Reset(rst_n), .Clear(clr), .Data_in(din), .Data_valid(dv),
    .Data_ready(rdy[1]), .Mem_Address(addr[1]), .Mem_Data(mdat[1]),
    .Mem_WR(wr[1]), .WR_Count(cnt[1]), .Full(full[1]), .Busy(busy[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: address sequence as a table, writer as counters.
  // ---------------------------------------------------------------------------
  logic [15:0] seq [0:2047];
  int          m_cnt  [NI];
  int          m_idx  [NI];
  bit          m_busy [NI];
  logic [15:0] m_addr [NI];
  logic [7:0]  m_data [NI];
  logic [23:0] exp_q  [NI][$];
  logic [23:0] obs_q  [NI][$];
  int          seen   [int];
  bit          mon_en = 1'b0;

  function automatic int max_of(input int i);
    return (i == 0) ? int'(MAX_S) : int'(MAX_M);
  endfunction

  function automatic bit exp_ready(input int i);
    return (rst_n === 1'b1) && (clr === 1'b0) && !m_busy[i] && (m_cnt[i] != max_of(i));
  endfunction

  // Model advances on the same edge as the DUT; on an accepted byte the
  // expected write is pushed into the scoreboard.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n !== 1'b1) begin
        m_busy[i] = 1'b0; m_cnt[i] = 0; m_idx[i] = 0;
        m_addr[i] = 16'h0; m_data[i] = 8'h0;
        if (i == 1) seen.delete();
      end else if (clr === 1'b1) begin
        m_busy[i] = 1'b0; m_cnt[i] = 0; m_idx[i] = 0;
        if (i == 1) seen.delete();
      end else if (m_busy[i]) begin
        m_busy[i] = 1'b0;
        if (m_cnt[i] < max_of(i)) m_cnt[i]++;
        m_idx[i]++;
      end else if (dv === 1'b1 && exp_ready(i)) begin
        m_addr[i] = seq[m_idx[i]];
        m_data[i] = din;
        exp_q[i].push_back({seq[m_idx[i]], din});
        m_busy[i] = 1'b1;
      end
    end
  end

  // Monitor: compares visible state every cycle, pops the scoreboard per strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        logic [23:0] e;
        check("data_ready", i, rdy[i], exp_ready(i));
        check("busy", i, busy[i], m_busy[i]);
        check("mem_wr", i, wr[i], m_busy[i]);
        check("wr_count", i, cnt[i], m_cnt[i]);
        check("full", i, full[i], m_cnt[i] == max_of(i));
        check("mem_address", i, addr[i], m_addr[i]);
        check("mem_data", i, mdat[i], m_data[i]);
        if (wr[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write[%0d]: got %0h/%0h, expected none", i, addr[i], mdat[i]);
          end else begin
            e = exp_q[i].pop_front();
            check("write", i, {addr[i], mdat[i]}, e);
          end
          obs_q[i].push_back({addr[i], mdat[i]});
          if (i == 1) begin
            check("addr_nonzero", i, addr[i] != 16'h0, 1);
            check("addr_unique", i, seen.exists(int'(addr[i])), 0);
            seen[int'(addr[i])] = 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    dv = 1'b1; din = b;
    while (!hs && t < 20) begin
      @(negedge clk); hs = rdy[1];
      @(posedge clk); #1;
      t++;
    end
    dv = 1'b0;
    if (!hs) begin
      n_checks++; n_errors++;
      $display("FAIL handshake_timeout[1]: got no handshake, expected one within 20 cycles");
    end
  endtask

  task automatic do_clear();
    clr = 1'b1; tick(); clr = 1'b0;
    obs_q[0].delete(); obs_q[1].delete();
  endtask

  logic [15:0] lfsr_ref [12];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog[0]: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s, fb;
    lfsr_ref = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
                 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801};
    s = 1;
    for (int k = 0; k < 2048; k++) begin
      seq[k] = s[15:0];
      fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
      s = ((s << 1) | fb) & 16'hFFFF;
    end

    rst_n = 1'b0; clr = 1'b0; dv = 1'b0; din = 8'h00;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    // Three handshakes after reset release.
    send(8'hA5); send(8'h3C); send(8'h7E);
    tick(); tick();
    check("count_after_3", 1, cnt[1], 3);
    check("n_writes_3", 1, obs_q[1].size(), 3);
    if (obs_q[1].size() == 3) begin
      check("w0", 1, obs_q[1][0], 24'h0001A5);
      check("w1", 1, obs_q[1][1], 24'h00023C);
      check("w2", 1, obs_q[1][2], 24'h00047E);
    end

    // Data_valid held for 6 cycles: every other cycle is accepted.
    do_clear();
    dv = 1'b1; din = 8'h11;
    repeat (6) tick();
    dv = 1'b0;
    tick(); tick();
    check("held_valid_writes", 1, obs_q[1].size(), 3);
    for (int k = 0; k < 3 && k < obs_q[1].size(); k++)
      check("held_valid_addr", 1, obs_q[1][k][23:8], lfsr_ref[k]);

    // Twelve writes walk the LFSR through eleven steps.
    do_clear();
    for (int k = 0; k < 12; k++) send(8'($urandom));
    tick(); tick();
    check("seq_writes", 1, obs_q[1].size(), 12);
    for (int k = 0; k < 12 && k < obs_q[1].size(); k++)
      check("seq_addr", 1, obs_q[1][k][23:8], lfsr_ref[k]);

    // Small instance fills after four writes; the fifth byte is dropped.
    do_clear();
    for (int k = 0; k < 5; k++) send(8'(8'h40 + k));
    tick(); tick();
    check("full_flag", 0, full[0], 1);
    check("full_count", 0, cnt[0], 4);
    check("full_ready", 0, rdy[0], 0);
    check("full_writes", 0, obs_q[0].size(), 4);
    do_clear();
    check("cleared_full", 0, full[0], 0);
    check("cleared_count", 0, cnt[0], 0);
    send(8'h99);
    tick(); tick();
    check("after_clear_writes", 0, obs_q[0].size(), 1);
    if (obs_q[0].size() == 1) check("after_clear_addr", 0, obs_q[0][0], 24'h000199);

    // Clear during the WRITE cycle of the second write.
    do_clear();
    send(8'h21); send(8'h22);
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    check("clr_in_write_strobed", 1, obs_q[1].size(), 2);
    if (obs_q[1].size() == 2) check("clr_in_write_addr", 1, obs_q[1][1], 24'h000222);
    check("clr_in_write_count", 1, cnt[1], 0);
    obs_q[1].delete();
    send(8'h23);
    tick(); tick();
    if (obs_q[1].size() == 1) check("clr_restart_addr", 1, obs_q[1][0], 24'h000123);
    else check("clr_restart_writes", 1, obs_q[1].size(), 1);

    // Reset during WRITE.
    do_clear();
    send(8'h31); send(8'h32);
    rst_n = 1'b0; tick();
    check("rst_mem_wr", 1, wr[1], 0);
    check("rst_addr", 1, addr[1], 0);
    check("rst_data", 1, mdat[1], 0);
    check("rst_count", 1, cnt[1], 0);
    rst_n = 1'b1;
    obs_q[1].delete();
    send(8'h33);
    tick(); tick();
    if (obs_q[1].size() == 1) check("rst_restart_addr", 1, obs_q[1][0], 24'h000133);
    else check("rst_restart_writes", 1, obs_q[1].size(), 1);

    // Random traffic with occasional Clear; the model checks every cycle.
    for (int k = 0; k < 300; k++) begin
      dv  = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    dv = 1'b0; clr = 1'b0;
    tick();

    // Soak: fill the main instance, every address unique and nonzero.
    do_clear();
    for (int k = 0; k < int'(MAX_M); k++) send(8'($urandom));
    tick(); tick();
    check("soak_full", 1, full[1], 1);
    check("soak_count", 1, cnt[1], MAX_M);
    check("soak_unique", 1, seen.num(), MAX_M);
    dv = 1'b1; din = 8'hEE;
    repeat (4) tick();
    dv = 1'b0;
    tick();
    check("soak_no_extra", 1, obs_q[1].size(), MAX_M);

    check("scoreboard_empty", 0, exp_q[0].size(), 0);
    check("scoreboard_empty", 1, exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_mem_writer.md
Name: lfsr_mem_writer

Overview:
- Write-side sequencer for the LFSR-addressed associative memory.
- Accepts bytes over a valid/ready handshake and writes each one to the memory at the next address of a 16-bit maximal-length LFSR.
- Maintains the write count that the search side uses to select LFSR degree.
- Stops accepting data when the address space is exhausted.

Parameters:
- ADDR_W, 16, address/LFSR width (fixed at 16; taps defined for 16 only).
- DATA_W, 8, data byte width.
- SEED, 16'h0001, first address written after reset/Clear; must be nonzero, and a zero value is replaced by 16'h0001 in RTL.
- MAX_WRITES, 16'hFFFF, writes accepted before Full (LFSR period).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- Clear  in  1  synchronous restart: seed, count, FSM back to initial; active-high.
- Data_in  in  DATA_W  byte to store.
- Data_valid  in  1  Data_in valid.
- Data_ready  out  1  writer can accept Data_in this cycle.
- Mem_Address  out  ADDR_W  memory write address (registered).
- Mem_Data  out  DATA_W  memory write data (registered).
- Mem_WR  out  1  one-cycle write strobe (registered).
- WR_Count  out  16  number of completed writes.
- Full  out  1  WR_Count == MAX_WRITES.
- Busy  out  1  write in flight (state WRITE).

Behaviour:
- Reset (Reset==0 at a Clock edge):
  - State IDLE, LFSR=SEED, WR_Count=0.
  - Mem_WR=0, Mem_Address=0, Mem_Data=0.
  - Full=0, Busy=0, Data_ready=0 during reset, 1 the first cycle after.
- LFSR is Fibonacci: next = {s[14:0], s[15]^s[13]^s[12]^s[10]} (x^16+x^14+x^13+x^11+1), period 65535. It never reaches 0 from a nonzero seed.
- FSM states, with Data_ready = (state==IDLE) && !Full:
  - IDLE: on Data_valid && Data_ready, latch Mem_Data<=Data_in and Mem_Address<=LFSR, set Mem_WR<=1, go to WRITE.
  - WRITE: Mem_WR is high this cycle. At the edge: Mem_WR<=0, LFSR<=next, WR_Count<=WR_Count+1, Busy<=0. Go to FULL if the new count == MAX_WRITES, else IDLE.
  - FULL: Data_ready=0 and Full=1. Held until Clear or Reset.
- Latency:
  - Handshake at edge N gives Mem_WR high during cycle N+1.
  - WR_Count updates at edge N+2.
  - Throughput is 1 byte per 2 cycles. Back-to-back Data_valid is accepted on every other cycle.
- Data_valid while Data_ready=0 is ignored: no latch, no side effects. The source must hold data until the handshake.
- Mem_Address/Mem_Data hold their last values outside WRITE.
- WR_Count saturates at MAX_WRITES and never wraps.
- Clear:
  - Has priority over everything except Reset. Next state IDLE, LFSR=SEED, WR_Count=0, Full=0, Mem_WR<=0.
  - Clear sampled during WRITE: Mem_WR is already high that cycle and the write still reaches memory. The count is not incremented and the LFSR is not advanced.
  - Clear with Data_valid in the same cycle: the handshake does not occur, and Data_ready is forced 0 that cycle.
- Reset mid-WRITE: same as Clear, plus all outputs take their reset values.

Decomposition:
- Shared package lfsr_mem_pkg holds:
  - state enum IDLE/WRITE/FULL (2-bit);
  - LFSR16_TAPS = 16'hB400;
  - LFSR16_SEED_DEFAULT = 16'h0001;
  - MAX_WRITES_16 = 16'hFFFF.
- One sub-module, lfsr16_step: combinational next-state from current state. Reused by the search-side LFSR for address-sequence agreement.

Test Plan:
- Reset release, then 3 handshakes with bytes A5, 3C, 7E:
  - Mem_WR pulses write (0001,A5), (0002,3C), (0004,7E), each one cycle.
  - WR_Count steps 1,2,3.
  - Data_ready low each WRITE cycle.
- Data_valid held high 6 cycles with constant 11:
  - Exactly 3 writes to 0001, 0002, 0004.
  - Data_ready toggles 1,0,1,0,1,0.
- Step LFSR 11 times from 0001:
  - Addresses 0001…0400, then 0801.
  - Confirms taps/feedback.
- Full, with MAX_WRITES overridden to 4: 5 handshakes attempted.
  - 4 writes occur, then Full=1, Data_ready=0, WR_Count=4.
  - The 5th byte is never written.
  - Clear then gives Full=0, WR_Count=0, and the next write goes to 0001.
- Clear asserted in the WRITE cycle of the 2nd write:
  - Write to 0002 still strobes.
  - WR_Count=0 afterwards and the next write goes to 0001.
- Reset asserted during WRITE:
  - Next cycle all outputs equal reset values and the LFSR restarts at SEED.
  - Full soak: 65535 writes produce unique nonzero addresses, then Full=1.
